branch_update_scheduler: RTL

Sequences resolved-branch outcomes into the branch predictor's tables. It buffers updates from the execute stage in a small FIFO and drains one per cycle into the local history table's write port. One cycle later it issues the matching pattern-history-table update, indexed by the pre-shift history. It also flags fetch-side reads whose table entry still has a queued update.

---
 rtl/branch_update_scheduler_pkg.sv | 17 +
 rtl/branch_update_scheduler_update_fifo.sv | 82 ++++++++
 rtl/branch_update_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/branch_update_scheduler_pkg.sv
// Shared branch-predictor definitions: default table widths and update-entry layout.
// The entry layout is common to the scheduler, the history table and the PHT.
package branch_update_scheduler_pkg;

    localparam int INDEX_LEN_DEF   = 7;
    localparam int HISTORY_LEN_DEF = 10;
    localparam int DEPTH_DEF       = 4;

    // Update entry = {index, taken}; taken sits in bit 0.
    localparam int ENT_TAKEN_OFS = 0;
    localparam int ENT_INDEX_OFS = 1;

    function automatic int entry_width(input int index_len);
        return index_len + 1;
    endfunction

endpackage

// File: rtl/branch_update_scheduler_update_fifo.sv
// Synchronous FIFO with occupancy count and per-slot valid bits exposed for associative lookup.
// Caller must not push when full nor pop when empty.
module update_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [DEPTH*WIDTH-1:0]   entries,
    output logic [DEPTH-1:0]         entry_vld
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        if (pop) begin
            rd_ptr_d         = rd_ptr_q + 1'b1;
            vld_d[rd_ptr_q]  = 1'b0;
        end
        if (push) begin
            wr_ptr_d         = wr_ptr_q + 1'b1;
            vld_d[wr_ptr_q]  = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Storage needs no reset: slot contents are only meaningful under vld_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_comb begin
        entries = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries[i*WIDTH +: WIDTH] = mem_q[i];
        end
    end

    assign rdata     = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign entry_vld = vld_q;

endmodule

// File: rtl/branch_update_scheduler.sv
// Buffers resolved-branch updates and issues them as an LHT shift followed one cycle later by the PHT write.
// Latency: accept at edge N -> LHT shift in cycle N+1, PHT write in cycle N+2; hold stalls only the FIFO head.
module branch_update_scheduler
    import branch_update_scheduler_pkg::*;
#(
    parameter int INDEX_LEN   = INDEX_LEN_DEF,
    parameter int HISTORY_LEN = HISTORY_LEN_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [INDEX_LEN-1:0]     upd_index,
    input  logic                     upd_taken,
    input  logic                     hold,
    output logic                     lht_write_enabled,
    output logic [INDEX_LEN-1:0]     lht_pc_bits_write,
    output logic                     lht_taken_not_taken,
    input  logic [HISTORY_LEN-1:0]   lht_history_write,
    output logic                     pht_write_enabled,
    output logic [HISTORY_LEN-1:0]   pht_index,
    output logic                     pht_taken,
    input  logic [INDEX_LEN-1:0]     rd_index,
    output logic                     rd_pending,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);
    localparam int EW = entry_width(INDEX_LEN);

    logic [EW-1:0]       wdata;
    logic [EW-1:0]       head;
    logic [DEPTH*EW-1:0] entries;
    logic [DEPTH-1:0]    entry_vld;
    logic                full;
    logic                empty;
    logic                push;
    logic                issue;

    logic                   s2_vld_q;
    logic [HISTORY_LEN-1:0] s2_hist_q;
    logic                   s2_taken_q;

    assign upd_ready = reset & ~full;
    assign push      = upd_valid & upd_ready;
    // Gating with reset keeps a reset cycle from emitting a partial LHT shift.
    assign issue     = reset & ~empty & ~hold;

    always_comb begin
        wdata                              = '0;
        wdata[ENT_TAKEN_OFS]               = upd_taken;
        wdata[ENT_INDEX_OFS +: INDEX_LEN]  = upd_index;
    end

    update_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (issue),
        .wdata     (wdata),
        .rdata     (head),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .entries   (entries),
        .entry_vld (entry_vld)
    );

    assign lht_write_enabled   = issue;
    assign lht_pc_bits_write   = empty ? '0   : head[ENT_INDEX_OFS +: INDEX_LEN];
    assign lht_taken_not_taken = empty ? 1'b0 : head[ENT_TAKEN_OFS];

    // Pre-shift history is captured here; it never reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_vld_q   <= 1'b0;
            s2_hist_q  <= '0;
            s2_taken_q <= 1'b0;
        end else begin
            s2_vld_q <= issue;
            if (issue) begin
                s2_hist_q  <= lht_history_write;
                s2_taken_q <= head[ENT_TAKEN_OFS];
            end
        end
    end

    assign pht_write_enabled = s2_vld_q;
    assign pht_index         = s2_hist_q;
    assign pht_taken         = s2_taken_q;
    assign busy              = ~empty | s2_vld_q;

    always_comb begin
        rd_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (entries[i*EW + ENT_INDEX_OFS +: INDEX_LEN] == rd_index)) begin
                rd_pending = 1'b1;
            end
        end
    end

    logic unused_taken_bits;
    always_comb begin
        unused_taken_bits = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            unused_taken_bits = unused_taken_bits ^ entries[i*EW + ENT_TAKEN_OFS];
        end
    end

endmodule
